// File: rtl/window_assembler.sv
// Assembles a MASK_WIDTH x MASK_WIDTH pixel window from streamed mask columns.
// Row borders are mirrored (no duplication) using only the column shift register.
module window_assembler #(
  parameter int ROW_WIDTH  = 340,
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     col_valid,
  output logic                                     col_ready,
  input  logic [PIX_BIT*MASK_WIDTH-1:0]            col_in,
  output logic                                     win_valid,
  output logic                                     win_last,
  output logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] win_out
);

  localparam int W    = ROW_WIDTH;
  localparam int M    = MASK_WIDTH;
  localparam int H    = (M - 1) / 2;
  localparam int COLW = PIX_BIT * M;
  localparam int CW   = $clog2(W);
  localparam int FW   = $clog2(H + 1);
  localparam int AW   = $clog2(M);

  typedef enum logic [1:0] {PRIME, STREAM, FLUSH} state_t;

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_cnt;
  logic [FW-1:0]          r_fcnt;
  logic [M-1:0][COLW-1:0] r_sr;
  logic [M-1:0][COLW-1:0] w_src;
  logic [M-1:0][COLW-1:0] w_win;
  logic                   w_xfer, w_emit, w_last;
  int                     w_n, w_c;

  // Shift-register age of tap j: 0 = newest column n, mirrored at both borders.
  function automatic logic [AW-1:0] tap_age(input int n, input int c, input int j);
    int k, a;
    k = c + j - H;
    if (k < 0)          k = -k;
    else if (k > W - 1) k = 2 * (W - 1) - k;
    a = n - k;
    return (a >= 0 && a < M) ? AW'(a) : '0;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= PRIME;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      PRIME:   if (w_xfer && r_cnt == CW'(H - 1)) w_next = STREAM;
      STREAM:  if (w_xfer && r_cnt == CW'(W - 1)) w_next = FLUSH;
      FLUSH:   if (r_fcnt == FW'(H - 1))          w_next = PRIME;
      default: w_next = PRIME;
    endcase
  end

  always_comb begin
    col_ready = (r_state != FLUSH);
    w_xfer    = col_valid && (r_state != FLUSH);
    w_emit    = (r_state == STREAM && w_xfer) || (r_state == FLUSH);
    w_last    = (r_state == FLUSH) && (r_fcnt == FW'(H - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_xfer) r_cnt <= (r_cnt == CW'(W - 1)) ? '0 : r_cnt + CW'(1);
      if (r_state == FLUSH) r_fcnt <= (r_fcnt == FW'(H - 1)) ? '0 : r_fcnt + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) r_sr <= {r_sr[M-2:0], col_in};
  end

  // Window is built from the post-shift view so it registers on the transfer edge.
  always_comb begin
    w_src = w_xfer ? {r_sr[M-2:0], col_in} : r_sr;
    if (r_state == FLUSH) begin
      w_n = W - 1;
      w_c = W - H + int'(r_fcnt);
    end else begin
      w_n = int'(r_cnt);
      w_c = int'(r_cnt) - H;
    end
    w_win = '0;
    for (int j = 0; j < M; j++) w_win[j] = w_src[tap_age(w_n, w_c, j)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_out   <= '0;
    end else begin
      win_valid <= w_emit;
      win_last  <= w_last;
      if (w_emit) win_out <= w_win;
    end
  end

endmodule

// File: tb/tb_window_assembler.sv
// Scoreboard bench: DUT A (mask 3, row 8) and DUT B (mask 7, row 10).
// Pixel in row r of column k is k + 16*r, so row order and column order are both visible.
module tb_window_assembler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         va, ra, wva, wla;
  logic [23:0]  ca;
  logic [71:0]  woa;
  logic         vb, rb, wvb, wlb;
  logic [55:0]  cb;
  logic [391:0] wob;

  typedef struct {
    logic [391:0] win;
    int           last;
    int           cyc;
    int           c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  localparam logic [391:0] HAND_A0 = 392'h21_11_01_20_10_00_21_11_01;
  localparam logic [391:0] HAND_A7 = 392'h26_16_06_27_17_07_26_16_06;

  window_assembler #(.ROW_WIDTH(8), .PIX_BIT(8), .MASK_WIDTH(3)) u_a (
    .clk(clk), .reset(reset), .col_valid(va), .col_ready(ra), .col_in(ca),
    .win_valid(wva), .win_last(wla), .win_out(woa));

  window_assembler #(.ROW_WIDTH(10), .PIX_BIT(8), .MASK_WIDTH(7)) u_b (
    .clk(clk), .reset(reset), .col_valid(vb), .col_ready(rb), .col_in(cb),
    .win_valid(wvb), .win_last(wlb), .win_out(wob));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_w(input string nm, input logic [391:0] act, input logic [391:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [391:0] mk_col(input int m, input int col);
    logic [391:0] d;
    d = '0;
    for (int r = 0; r < m; r++) d[r*8 +: 8] = 8'(col + 16 * r);
    return d;
  endfunction

  function automatic logic [391:0] exp_win(input int m, input int w, input int c);
    logic [391:0] d;
    int h, k;
    d = '0;
    h = (m - 1) / 2;
    for (int j = 0; j < m; j++) begin
      k = c + j - h;
      if (k < 0)          k = -k;
      else if (k > w - 1) k = 2 * (w - 1) - k;
      for (int r = 0; r < m; r++) d[(j*m + r)*8 +: 8] = 8'(k + 16 * r);
    end
    return d;
  endfunction

  function automatic logic [391:0] rnd();
    return {328'b0, $urandom(), $urandom()};
  endfunction

  function automatic logic rdy(input int sel);
    return (sel != 0) ? rb : ra;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [391:0] d);
    if (sel == 0) begin va = v; ca = d[23:0]; end
    else          begin vb = v; cb = d[55:0]; end
  endtask

  task automatic push(input int sel, input int m, input int w, input int c, input int ecyc);
    exp_t e;
    e.win  = exp_win(m, w, c);
    e.last = (c == w - 1) ? 1 : 0;
    e.cyc  = ecyc;
    e.c    = c;
    if (sel == 0) qa.push_back(e);
    else          qb.push_back(e);
  endtask

  // Called and returning at a negedge; garbage with valid=1 is offered while not ready.
  task automatic drive_row(input int sel, input int row, input bit gaps, input int stop_after);
    int m, w, h, tmo, n;
    m = (sel != 0) ? 7 : 3;
    w = (sel != 0) ? 10 : 8;
    h = (m - 1) / 2;
    for (int col = 0; col < w; col++) begin
      if (gaps && ((col * 5 + row) % 3 == 0)) begin
        for (int g = 0; g < 1 + col % 2; g++) begin
          set_in(sel, 1'b0, rnd());
          @(negedge clk);
        end
      end
      tmo = 0;
      while (!rdy(sel) && tmo < 20) begin
        set_in(sel, 1'b1, rnd());
        tmo++;
        @(negedge clk);
      end
      if (tmo >= 20) begin
        checks++; fails++;
        $display("FAIL ready_timeout dut=%0d col=%0d got=0 want=1", sel, col);
      end
      set_in(sel, 1'b1, mk_col(m, col));
      if (col >= h) push(sel, m, w, col - h, cyc + 1);
      if (col == w - 1) for (int i = 1; i <= h; i++) push(sel, m, w, w - 1 - h + i, cyc + 1 + i);
      @(negedge clk);
      if (col == stop_after) return;
    end
    n = 0;
    while (!rdy(sel) && n < 20) begin
      set_in(sel, 1'b1, rnd());
      n++;
      @(negedge clk);
    end
    check_i((sel != 0) ? "flush_len_b" : "flush_len_a", n, h);
  endtask

  task automatic mon(input int sel, input logic v, input logic l, input logic [391:0] wo);
    exp_t e;
    int   sz;
    sz = (sel != 0) ? qb.size() : qa.size();
    if (v) begin
      if (sz == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_win dut=%0d cyc=%0d got=1 want=0", sel, cyc);
      end else begin
        if (sel != 0) e = qb.pop_front();
        else          e = qa.pop_front();
        check_w((sel != 0) ? "win_b" : "win_a", wo, e.win);
        check_i("win_last", int'(l), e.last);
        check_i("latency", cyc, e.cyc);
        if (sel == 0 && e.c == 0) check_w("hand_a_c0", wo, HAND_A0);
        if (sel == 0 && e.c == 7) check_w("hand_a_c7", wo, HAND_A7);
      end
    end else begin
      check_i("last_idle", int'(l), 0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, wva, wla, {320'b0, woa});
      mon(1, wvb, wlb, wob);
    end
  end

  initial begin
    va = 1'b0; vb = 1'b0; ca = '0; cb = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_i("rst_ready_a", int'(ra), 1);
    check_i("rst_valid_a", int'(wva), 0);
    check_i("rst_last_a", int'(wla), 0);
    check_w("rst_out_a", {320'b0, woa}, '0);
    check_i("rst_ready_b", int'(rb), 1);
    check_i("rst_valid_b", int'(wvb), 0);
    check_w("rst_out_b", wob, '0);
    reset = 1'b0;

    drive_row(0, 0, 1'b0, -1);
    drive_row(0, 1, 1'b0, -1);
    drive_row(0, 2, 1'b1, -1);
    drive_row(0, 3, 1'b1, -1);
    set_in(0, 1'b0, '0);

    drive_row(1, 0, 1'b0, -1);
    drive_row(1, 1, 1'b0, -1);
    drive_row(1, 2, 1'b1, -1);
    set_in(1, 1'b0, '0);

    // Abandon a row after column 5, then restart cleanly.
    drive_row(0, 4, 1'b0, 5);
    set_in(0, 1'b0, '0);
    #1 reset = 1'b1;
    #1;
    check_i("midrst_valid", int'(wva), 0);
    check_i("midrst_last", int'(wla), 0);
    check_w("midrst_out", {320'b0, woa}, '0);
    check_i("midrst_ready", int'(ra), 1);
    @(negedge clk);
    reset = 1'b0;
    drive_row(0, 5, 1'b0, -1);
    set_in(0, 1'b0, '0);

    repeat (6) @(negedge clk);
    check_i("qa_drained", qa.size(), 0);
    check_i("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/window_assembler.md
WINDOW_ASSEMBLER -- requirements
Module: window_assembler

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 340, meaning pixels per image row (W); W >= MASK_WIDTH.
REQ-002 SHALL have parameter PIX_BIT, default 8, meaning bits per pixel.
REQ-003 SHALL have parameter MASK_WIDTH, default 7, meaning window width and height; odd, 3..7; H = (MASK_WIDTH-1)/2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port col_valid, input, 1, meaning col_in carries a valid mask column.
REQ-007 SHALL have port col_ready, output, 1, meaning the block accepts col_in this cycle.
REQ-008 SHALL have port col_in, input, PIX_BIT*MASK_WIDTH, meaning one column of the mask from the row buffers, row 0 in the LSBs.
REQ-009 SHALL have port win_valid, output, 1, meaning win_out holds a complete window this cycle.
REQ-010 SHALL have port win_last, output, 1, meaning the current window is the last (centre W-1) of its row.
REQ-011 SHALL have port win_out, output, PIX_BIT*MASK_WIDTH*MASK_WIDTH, meaning the full window, column-major: slice j (j=0..MASK_WIDTH-1, LSB first) is the column at offset j-H from the centre, each slice in col_in order.

Function
REQ-012 SHALL accept a column only when col_valid and col_ready are both 1 (a transfer).
REQ-013 SHALL keep the last MASK_WIDTH transferred columns of the current row in a column shift register, shifting only on a transfer.
REQ-014 SHALL maintain an input column counter 0..W-1, incremented per transfer and cleared after the transfer of column W-1.
REQ-015 SHALL implement states PRIME, STREAM, FLUSH.
REQ-016 PRIME: col_ready=1, no window output; after the transfer of column H-1 -> STREAM (H transfers total).
REQ-017 STREAM: col_ready=1; the transfer of column n (H <= n <= W-1) SHALL produce win_valid=1 on the next cycle with centre c = n-H.
REQ-018 STREAM: the transfer of column W-1 -> FLUSH.
REQ-019 FLUSH: col_ready=0 for exactly H cycles, emitting one window per cycle with centres W-H..W-1 in order and no gaps; then -> PRIME.
REQ-020 Window tap j with centre c SHALL take source column k = c+j-H, mirrored without duplication: k<0 -> -k; k>W-1 -> 2(W-1)-k.
REQ-021 Every mirrored source column SHALL be taken from the column shift register; no extra storage and no extra cycles at the left border.
REQ-022 win_out, win_valid and win_last SHALL be registered; latency is 1 cycle from the transfer of column c+H to the window with centre c.
REQ-023 win_last SHALL be 1 only with win_valid=1 and centre W-1.
REQ-024 No output backpressure: a window is valid for exactly one cycle.
REQ-025 A cycle with col_valid=0 in PRIME or STREAM SHALL emit win_valid=0 and SHALL change no state.
REQ-026 Col_in presented during FLUSH SHALL be ignored and held by the source (col_ready=0).
REQ-027 Consecutive rows SHALL stream back-to-back: the first PRIME transfer of the next row is allowed on the cycle after the last FLUSH cycle.

Reset
REQ-028 On reset=1, asynchronously: state=PRIME, counters=0, col_ready=1, win_valid=0, win_last=0, win_out=0.
REQ-029 Reset asserted mid-row or mid-FLUSH SHALL abandon the partial row; after release the next transfer is column 0.
REQ-030 The column shift register contents need not be reset.

Verification
REQ-031 MASK_WIDTH=3, W=8, each column pixel = column index, continuous col_valid -> centre 0 window = cols {1,0,1}, first win_valid 2 cycles after the first transfer.
REQ-032 Same setup -> centres 0..7 on 8 consecutive cycles; centre 7 = {6,7,6} with win_last=1; col_ready=0 for exactly 1 cycle after column 7.
REQ-033 MASK_WIDTH=7, W=10 -> centre 0 = {3,2,1,0,1,2,3}; centre 9 = {6,7,8,9,8,7,6}; 3 FLUSH cycles.
REQ-034 Random col_valid gaps, two back-to-back rows -> window sequence and contents identical to the gap-free run, with no win_valid during gaps.
REQ-035 Reset pulse after column 5 of a row -> all outputs 0 immediately; the next row restarts at PRIME and produces correct centre-0 windows.
REQ-036 col_valid=1 held during FLUSH with changing col_in -> no transfer counted; the next row's windows are unaffected.
